// File: rtl/keypad_pkg.sv
// keypad_pkg: scanner state encoding, matrix constants and key-code helpers.
package keypad_pkg;
    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;
    localparam logic [3:0] COL_RESET = 4'b1110;
    localparam logic [3:0] ROW_IDLE = 4'hF;
    function automatic logic one_low(input logic [3:0] v);
        return v == 4'b1110 || v == 4'b1101 || v == 4'b1011 || v == 4'b0111;
    endfunction
    function automatic logic [1:0] low_idx(input logic [3:0] v);
        return !v[0] ? 2'd0 : !v[1] ? 2'd1 : !v[2] ? 2'd2 : 2'd3;
    endfunction
    function automatic logic [3:0] key_code_of(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction
endpackage

// File: rtl/keypad_tick.sv
// keypad_tick: one-cycle scan tick every CLK_FREQ/SCAN_HZ clocks.
module keypad_tick #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int SCAN_HZ = 1000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int DIV = CLK_FREQ / SCAN_HZ;
    localparam int W = $clog2(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk)
        if (!reset || cnt == LAST) cnt <= '0;
        else cnt <= cnt + 1'b1;
    assign tick = cnt == LAST;
endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 keypad scanner with debounce and a valid/ready key-event port.
// Define KEYPAD_AUTOREPEAT_EN to re-emit held keys after HOLD_SCANS, then every REPEAT_SCANS.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int SCAN_HZ = 1000,
    parameter int DEBOUNCE_SCANS = 8,
    parameter int HOLD_SCANS = 500,
    parameter int REPEAT_SCANS = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       overrun
);
    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_SCANS - 1);
    state_t state;
    logic [3:0] sync0, row_s, code;
    logic [DW-1:0] cnt;
    logic tick, idle, match, emit, rep_hit;
    keypad_tick #(.CLK_FREQ(CLK_FREQ), .SCAN_HZ(SCAN_HZ)) u_tick (
        .clk(clk),
        .reset(reset),
        .tick(tick)
    );
    always_ff @(posedge clk)
        if (!reset) {row_s, sync0} <= '1;
        else {row_s, sync0} <= {sync0, row_in};
    assign idle = row_s == ROW_IDLE;
    assign match = row_s == ~(4'b0001 << code[3:2]);
    assign emit = tick && (state == DEBOUNCE && match && cnt == DB_LAST || rep_hit);
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RW = $clog2(HOLD_SCANS + 1);
    localparam logic [RW-1:0] HOLD_LAST = RW'(HOLD_SCANS - 1);
    localparam logic [RW-1:0] REP_BASE = RW'(HOLD_SCANS - REPEAT_SCANS);
    logic [RW-1:0] rep_cnt;
    if (CLK_FREQ / SCAN_HZ < 2 || DEBOUNCE_SCANS < 2 || REPEAT_SCANS < 1 || HOLD_SCANS < REPEAT_SCANS) begin : g_bad_cfg
        $error("keypad_scan: invalid parameters");
    end
    assign rep_hit = state == PRESSED && !idle && rep_cnt == HOLD_LAST;
    // Reloading to HOLD-REPEAT makes every later hit land REPEAT_SCANS apart.
    always_ff @(posedge clk)
        if (!reset || state != PRESSED) rep_cnt <= '0;
        else if (tick && !idle) rep_cnt <= rep_hit ? REP_BASE : rep_cnt + 1'b1;
`else
    if (CLK_FREQ / SCAN_HZ < 2 || DEBOUNCE_SCANS < 2 || HOLD_SCANS < 0 || REPEAT_SCANS < 0) begin : g_bad_cfg
        $error("keypad_scan: invalid parameters");
    end
    assign rep_hit = 1'b0;
`endif
    always_ff @(posedge clk) begin
        overrun <= 1'b0;
        if (!reset) begin
            state <= SCAN;
            col_out <= COL_RESET;
            code <= '0;
            cnt <= '0;
            key_code <= '0;
            key_valid <= 1'b0;
            key_held <= 1'b0;
        end else begin
            if (emit && key_valid && !key_ready) overrun <= 1'b1;
            else if (emit) begin
                key_code <= code;
                key_valid <= 1'b1;
            end else if (key_valid && key_ready) key_valid <= 1'b0;
            if (tick)
                case (state)
                    SCAN:
                        if (one_low(row_s)) begin
                            code <= key_code_of(low_idx(row_s), low_idx(col_out));
                            cnt <= DW'(1);
                            state <= DEBOUNCE;
                        end else col_out <= {col_out[2:0], col_out[3]};
                    DEBOUNCE:
                        if (!match) begin
                            cnt <= '0;
                            state <= SCAN;
                            col_out <= {col_out[2:0], col_out[3]};
                        end else if (cnt == DB_LAST) begin
                            key_held <= 1'b1;
                            state <= PRESSED;
                        end else cnt <= cnt + 1'b1;
                    PRESSED:
                        if (idle) begin
                            cnt <= DW'(1);
                            state <= RELEASE;
                        end
                    RELEASE:
                        if (!idle) state <= PRESSED;
                        else if (cnt == DB_LAST) begin
                            cnt <= '0;
                            key_held <= 1'b0;
                            state <= SCAN;
                            col_out <= {col_out[2:0], col_out[3]};
                        end else cnt <= cnt + 1'b1;
                endcase
        end
    end
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: table vectors, corner sequences and random presses checked against a key-level reference model.
module tb_keypad_scan;
    localparam int DB = 4, HOLD = 6, REP = 3, PER = 10;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif
    logic clk = 1'b0, reset = 1'b0, key_ready = 1'b0;
    logic [3:0] row_in, col_out, key_code;
    logic key_valid, key_held, overrun;
    logic [15:0] keys = '0;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;
    keypad_scan #(
        .CLK_FREQ(1000), .SCAN_HZ(100), .DEBOUNCE_SCANS(DB), .HOLD_SCANS(HOLD), .REPEAT_SCANS(REP)
    ) dut (
        .clk(clk), .reset(reset), .row_in(row_in), .col_out(col_out), .key_code(key_code),
        .key_valid(key_valid), .key_ready(key_ready), .key_held(key_held), .overrun(overrun)
    );
    // Physical matrix: key bit r*4+c pulls row r low while column c is strobed.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
    end
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    // Reference model: tracks which column is strobed, how many consecutive scans saw the same lone key, and key events.
    logic [15:0] kd1, kd2;
    int m_cyc, m_col, m_streak, m_cand, m_rel, m_since, m_code;
    bit m_held, m_valid, m_over, m_live = 1'b0;
    always @(posedge clk) begin
        int lows, r0;
        bit emit;
        emit = 1'b0;
        m_over = 1'b0;
        if (!reset) begin
            m_live = 1'b1;
            m_cyc = 0; m_col = 0; m_streak = 0; m_cand = 0; m_rel = 0; m_since = 0;
            m_held = 1'b0; m_valid = 1'b0; m_code = 0; kd1 = '0; kd2 = '0;
        end else begin
            if (m_cyc % PER == PER - 1) begin
                lows = 0; r0 = 0;
                for (int r = 0; r < 4; r++)
                    if (kd2[r*4+m_col]) begin lows++; r0 = r; end
                if (m_held) begin
                    if (lows == 0) begin
                        m_since = 0;
                        m_rel++;
                        if (m_rel == DB) begin m_held = 1'b0; m_rel = 0; m_col = (m_col + 1) % 4; end
                    end else if (m_rel > 0) m_rel = 0;
                    else begin
                        m_since++;
                        if (AUTO && (m_since == HOLD || (m_since > HOLD && (m_since - HOLD) % REP == 0))) emit = 1'b1;
                    end
                end else if (lows == 1 && (m_streak == 0 || r0 * 4 + m_col == m_cand)) begin
                    m_cand = r0 * 4 + m_col;
                    m_streak++;
                    if (m_streak == DB) begin emit = 1'b1; m_held = 1'b1; m_streak = 0; m_since = 0; end
                end else begin
                    m_streak = 0;
                    m_col = (m_col + 1) % 4;
                end
            end
            if (emit) begin
                if (m_valid && !key_ready) m_over = 1'b1;
                else begin m_valid = 1'b1; m_code = m_cand; end
            end else if (m_valid && key_ready) m_valid = 1'b0;
            m_cyc++;
            kd2 = kd1;
            kd1 = keys;
        end
    end
    always @(negedge clk)
        if (m_live) begin
            check("col_out", int'(col_out), 15 ^ (1 << m_col));
            check("key_valid", int'(key_valid), int'(m_valid));
            check("key_code", int'(key_code), m_code);
            check("key_held", int'(key_held), int'(m_held));
            check("overrun", int'(overrun), int'(m_over));
        end
    // Event monitor: a new event is visible when valid is high and the previous one was not left unconsumed.
    logic pv = 1'b0, pr = 1'b0;
    int ev_cnt = 0, ov_cnt = 0;
    always @(posedge clk) begin
        pv <= key_valid;
        pr <= key_ready;
    end
    always @(negedge clk) begin
        if (key_valid === 1'b1 && !(pv && !pr)) ev_cnt++;
        if (overrun === 1'b1) ov_cnt++;
    end
    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic rand_clocks(input int n);
        repeat (n) begin
            key_ready = $urandom_range(0, 2) == 0;
            @(negedge clk);
        end
    endtask
    task automatic wait_held(input int limit, output bit got);
        got = 1'b0;
        for (int i = 0; i < limit && !got; i++) begin
            @(negedge clk);
            got = key_held;
        end
    endtask
    typedef struct {
        logic [15:0] k;
        bit ready;
        bit bounce;
        int hold;
        bit exp_held;
        int exp_events;
        int exp_over;
        int exp_code;
    } vec_t;
    task automatic run_vec(input vec_t v);
        int ev0, ov0;
        bit got;
        ev0 = ev_cnt;
        ov0 = ov_cnt;
        key_ready = v.ready;
        if (v.bounce) begin
            for (int i = 0; i < 7; i++) begin
                keys = i % 2 == 0 ? v.k : 16'h0;
                clocks(15);
            end
            check("bounce_quiet", ev_cnt - ev0, 0);
        end
        keys = v.k;
        wait_held(12 * PER, got);
        check("held_seen", int'(got), int'(v.exp_held));
        clocks(v.hold * PER);
        keys = '0;
        clocks(8 * PER);
        check("events", ev_cnt - ev0, v.exp_events);
        check("overruns", ov_cnt - ov0, v.exp_over);
        check("final_code", int'(key_code), v.exp_code);
        check("released", int'(key_held), 0);
        key_ready = 1'b0;
    endtask
    vec_t vecs[6];
    initial begin
        bit got;
        int ov0;
        vecs[0] = '{16'h0200, 1'b0, 1'b0, 2, 1'b1, 1, 0, 9};
        vecs[1] = '{16'h0080, 1'b0, 1'b1, 2, 1'b1, 1, 0, 7};
        vecs[2] = '{16'h0004, 1'b0, 1'b0, 2, 1'b1, 0, 1, 7};
        vecs[3] = '{16'h1001, 1'b0, 1'b0, 0, 1'b0, 0, 0, 7};
        vecs[4] = '{16'h8000, 1'b1, 1'b0, 20, 1'b1, AUTO ? 6 : 1, 0, 15};
        vecs[5] = '{16'h0010, 1'b0, 1'b0, 1, 1'b1, 1, 0, 4};
        clocks(3);
        check("rst_col", int'(col_out), 4'b1110);
        check("rst_valid", int'(key_valid), 0);
        check("rst_held", int'(key_held), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_code", int'(key_code), 0);
        reset = 1'b1;
        clocks(9);
        check("col_before_tick", int'(col_out), 4'b1110);
        clocks(1);
        check("col_after_tick", int'(col_out), 4'b1101);
        clocks(10);
        check("col_second_tick", int'(col_out), 4'b1011);
        run_vec(vecs[0]);
        key_ready = 1'b1;
        clocks(1);
        key_ready = 1'b0;
        check("consume_clears", int'(key_valid), 0);
        for (int i = 1; i < 6; i++) run_vec(vecs[i]);
        // Accept the pending event on the very clock the next one is emitted.
        ov0 = ov_cnt;
        keys = 16'h0400;
        got = 1'b0;
        for (int i = 0; i < 20 * PER && !got; i++) begin
            @(negedge clk);
            got = !m_held && m_streak == DB - 1 && m_cyc % PER == PER - 1;
        end
        check("emit_wait", int'(got), 1);
        key_ready = 1'b1;
        clocks(1);
        key_ready = 1'b0;
        check("swap_code", int'(key_code), 10);
        check("swap_valid", int'(key_valid), 1);
        check("swap_overrun", int'(overrun), 0);
        keys = '0;
        clocks(8 * PER);
        check("swap_no_overrun", ov_cnt - ov0, 0);
        keys = 16'h0020;
        clocks(6 * PER);
        reset = 1'b0;
        clocks(2);
        check("midrst_valid", int'(key_valid), 0);
        check("midrst_held", int'(key_held), 0);
        check("midrst_col", int'(col_out), 4'b1110);
        keys = '0;
        reset = 1'b1;
        for (int n = 0; n < 40; n++) begin
            logic [15:0] k;
            k = 16'h1 << $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) k = k | (16'h1 << $urandom_range(0, 15));
            keys = k;
            rand_clocks($urandom_range(1, 12) * PER + $urandom_range(0, PER - 1));
            keys = '0;
            rand_clocks($urandom_range(0, 8) * PER + $urandom_range(0, PER - 1));
        end
        key_ready = 1'b0;
        clocks(10 * PER);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/keypad_scan.md
# keypad_scan

4x4 matrix keypad scanner: the input-side counterpart of the board's multiplexed seven-segment display. Drives one active-low column strobe at a time, samples the active-low rows, debounces, and delivers one hex key code per press over a valid/ready handshake to the core, e.g. for echo on the display digits.

## Interface
- `CLK_FREQ`, 100_000_000: `clk` frequency in Hz.
- `SCAN_HZ`, 1000: scan tick rate; `CLK_FREQ/SCAN_HZ` must be ≥ 2.
- `DEBOUNCE_SCANS`, 8: consecutive identical samples required for both press and release.
- `HOLD_SCANS`, 500 / `REPEAT_SCANS`, 100: auto-repeat delay and period, in ticks. Used only with `KEYPAD_AUTOREPEAT_EN`.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-low.
- `row_in` in 4: keypad rows, active-low, externally pulled up, asynchronous.
- `col_out` out 4: column strobes, active-low, exactly one bit low.
- `key_code` out 4: `row_idx*4 + col_idx`.
- `key_valid` out 1: `key_code` holds an unconsumed event.
- `key_ready` in 1: consumer accepts the event.
- `key_held` out 1: a debounced key is currently down.
- `overrun` out 1: one-cycle pulse when an event was dropped.

## Operation
- `row_in` passes through a 2-flop synchronizer; FSM sees only `row_s`.
- `keypad_tick` generates a one-cycle `tick` every `CLK_FREQ/SCAN_HZ` clocks.
- FSM states: SCAN, DEBOUNCE, PRESSED, RELEASE.
- SCAN:
  - On `tick`, sample `row_s` for the current column.
  - If exactly one row is low: latch row/col, set count=1, go DEBOUNCE, and keep the column.
  - Otherwise rotate `col_out` 1110→1101→1011→0111→1110.
  - Multiple rows low is a ghost press: ignore it and keep rotating.
- DEBOUNCE: on each `tick`, a matching sample increments count; any mismatch returns to SCAN with rotation resuming.
- When count reaches `DEBOUNCE_SCANS`: emit the event, set `key_held`=1, go PRESSED.
- PRESSED (column frozen): on `tick`, a sample of 4'hF sets count=1 and goes RELEASE; anything else stays.
- RELEASE:
  - Each 4'hF `tick` increments count.
  - A non-F sample returns to PRESSED.
  - When count reaches `DEBOUNCE_SCANS`: `key_held`=0, go SCAN, rotate column.
- Emit rules:
  - If `key_valid`=0: load `key_code` and set `key_valid`.
  - If `key_valid`=1 and `key_ready`=0: drop the new code, keep the old one, pulse `overrun`.
  - If `key_valid`=1 and `key_ready`=1 in the same cycle: old event consumed, new code loaded, `key_valid` stays 1, no overrun.
- `key_valid && key_ready` with no emit clears `key_valid`. `key_code` is stable while `key_valid`=1.
- Counter widths:
  - Tick counter: `$clog2(CLK_FREQ/SCAN_HZ)`.
  - Debounce counter: `$clog2(DEBOUNCE_SCANS+1)`, saturating.
  - Repeat counter: `$clog2(HOLD_SCANS+1)`.

## Timing
- Reset values:
  - `col_out`=4'b1110, `key_code`=0, `key_valid`=0, `key_held`=0, `overrun`=0.
  - State SCAN; all counters 0.
  - Synchronizer flops reset to 1.
- Reset mid-operation discards any pending event.
- Row settling: column changes on a `tick`; rows are sampled on the next `tick`, giving one full tick period to settle.
- Input latency: 2 clocks (synchronizer).
- Press latency, counted from the first sampling `tick` that sees the key: `DEBOUNCE_SCANS-1` further ticks.
  - `key_valid` and `key_held` rise on the clock after that final tick.
- Release latency: `key_held` falls on the clock after the `DEBOUNCE_SCANS`-th all-high tick.
- `overrun` is high for exactly one clock.

## Configuration
- `KEYPAD_AUTOREPEAT_EN` defined:
  - In PRESSED, count ticks since the press was emitted.
  - At `HOLD_SCANS`, and every `REPEAT_SCANS` after that, re-emit the same code under the emit rules.
  - The counter clears on leaving PRESSED.
- `KEYPAD_AUTOREPEAT_EN` undefined:
  - Exactly one event per press.
  - No repeat counter is synthesized; `HOLD_SCANS`/`REPEAT_SCANS` are ignored.

## Structure
- Package `keypad_pkg`:
  - FSM state enum.
  - Column reset constant 4'b1110.
  - Row-idle constant 4'hF.
  - Code function `row*4+col`.
- Sub-module `keypad_tick`: parameterized tick divider with ports `clk`, `reset`, `tick`.
- Synchronizer, FSM and handshake stay in `keypad_scan`.

## Test plan
All scenarios use `CLK_FREQ`=1000, `SCAN_HZ`=100 (10-clock tick) and `DEBOUNCE_SCANS`=4.
- Reset with `reset`=0 for 3 clocks → `col_out`=1110, `key_valid`=0, `key_held`=0, `overrun`=0; `col_out` rotates every 10 clocks after release.
- Press row 2 / col 1 with `key_ready`=0 → `key_code`=4'h9, `key_valid`=1 one clock after the 4th matching tick. Then raise `key_ready` for 1 clock → `key_valid`=0.
- Bounce: row toggles every 15 clocks for 100 clocks, then holds → no event during bouncing; exactly one event after 4 stable ticks.
- Second press while `key_valid`=1 and `key_ready`=0 → `overrun` pulses once and `key_code` keeps the first value. Repeat with `key_ready`=1 on the emit clock → new code loaded, no overrun.
- Rows 0 and 3 low on the same column → no event; rotation continues.
- With `KEYPAD_AUTOREPEAT_EN`, `HOLD_SCANS`=6, `REPEAT_SCANS`=3, `key_ready`=1 and key held 20 ticks → events at press, +6, +9, +12 … ticks; single event without the macro.
